// File: rtl/add_seq_pkg.sv
// Shared types and constants for the byte-serial add/subtract sequencer.
package add_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte-index register width; at least one bit so NBYTES=1 still has a legal vector.
    function automatic int idx_w(input int nbytes);
        return (nbytes <= 1) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/byte_adder.sv
// Combinational 8-bit adder slice: sum = a + b + c_in, with carry-out.
module byte_adder
    import add_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              c_in,
    output logic [BYTE_W-1:0] sum,
    output logic              c_out
);

    logic [BYTE_W:0] full;

    // Widen to 9 bits so the carry-out falls out of the top bit.
    always_comb begin
        full  = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, c_in};
        sum   = full[BYTE_W-1:0];
        c_out = full[BYTE_W];
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one shared 8-bit slice walks the
// operands LSB byte first, chaining carry, with valid/ready on both sides.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] in_a,
    input  logic [BYTE_W*NBYTES-1:0] in_b,
    input  logic                     in_c,
    input  logic                     in_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] out_sum,
    output logic                     out_c,
    output logic                     busy
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int IW = idx_w(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            carry_q;
    logic            c_q;
    logic [IW-1:0]   idx_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    logic [BYTE_W-1:0] a_byte;
    logic [BYTE_W-1:0] b_byte;
    logic [BYTE_W-1:0] s_byte;
    logic              slice_c;

    // Select the operand bytes for the current index.
    always_comb begin
        a_byte = a_q[idx_q*BYTE_W +: BYTE_W];
        b_byte = b_q[idx_q*BYTE_W +: BYTE_W];
    end

    byte_adder u_slice (
        .a     (a_byte),
        .b     (b_byte),
        .c_in  (carry_q),
        .sum   (s_byte),
        .c_out (slice_c)
    );

    // Sequencer FSM with operand, carry, index and result registers.
    // Subtract is folded in at capture: B is stored inverted and carry seeded to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            c_q         <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= in_a;
                        b_q        <= in_sub ? ~in_b : in_b;
                        carry_q    <= in_sub | in_c;
                        idx_q      <= '0;
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[idx_q*BYTE_W +: BYTE_W] <= s_byte;
                    carry_q <= slice_c;
                    if (idx_q == LAST_IDX) begin
                        c_q         <= slice_c;
                        idx_q       <= '0;
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Registered outputs straight from the state registers.
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = out_valid_q;
        out_sum   = sum_q;
        out_c     = c_q;
        busy      = busy_q;
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl: NBYTES=4 and NBYTES=1 instances.
module tb_add_seq_ctrl;

    typedef struct {
        logic [31:0] sum;
        logic        c;
        int          xfer;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // NBYTES=4 instance signals
    logic        in_valid, in_ready, in_c, in_sub, out_valid, out_ready, out_c, busy;
    logic [31:0] in_a, in_b, out_sum;
    // NBYTES=1 instance signals
    logic        v1, r1, c1i, s1, ov1, or1, c1o, busy1;
    logic [7:0]  a1, b1, sum1;

    exp_t q4[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_seq_ctrl #(.NBYTES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_c(out_c), .busy(busy)
    );

    add_seq_ctrl #(.NBYTES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
        .in_a(a1), .in_b(b1), .in_c(c1i), .in_sub(s1),
        .out_valid(ov1), .out_ready(or1), .out_sum(sum1),
        .out_c(c1o), .busy(busy1)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Present an operand pair on the NBYTES=4 port until it transfers.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c, input logic sub,
                         input logic [31:0] exp_sum, input logic exp_c);
        exp_t e;
        bit   ok;
        @(posedge clk); #1;
        in_a = a; in_b = b; in_c = c; in_sub = sub; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            chk("issue_timeout", 32'd0, 32'd1);
        end else begin
            e.sum = exp_sum; e.c = exp_c; e.xfer = cyc + 1;
            q4.push_back(e);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Monitor for the NBYTES=4 instance: latency, hold stability, result compare.
    initial begin
        logic        prev_v;
        logic [31:0] hold_sum;
        logic        hold_c;
        exp_t        e;
        prev_v = 1'b0; hold_sum = '0; hold_c = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (out_valid && !prev_v) begin
                    if (q4.size() == 0) chk("unexpected_out4", 32'd1, 32'd0);
                    else chk("latency4", 32'(cyc - q4[0].xfer), 32'd4);
                    hold_sum = out_sum; hold_c = out_c;
                end else if (out_valid && prev_v) begin
                    chk("hold_sum4", out_sum, hold_sum);
                    chk("hold_c4", {31'd0, out_c}, {31'd0, hold_c});
                    chk("in_ready_done4", {31'd0, in_ready}, 32'd0);
                end
                if (out_valid && out_ready && q4.size() != 0) begin
                    e = q4.pop_front();
                    chk("sum4", out_sum, e.sum);
                    chk("c4", {31'd0, out_c}, {31'd0, e.c});
                end
                prev_v = out_valid;
            end
        end
    end

    // Monitor for the NBYTES=1 instance.
    initial begin
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (ov1 && !prev_v) begin
                    if (q1.size() == 0) chk("unexpected_out1", 32'd1, 32'd0);
                    else chk("latency1", 32'(cyc - q1[0].xfer), 32'd1);
                end
                if (ov1 && or1 && q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("sum1", {24'd0, sum1}, e.sum);
                    chk("c1", {31'd0, c1o}, {31'd0, e.c});
                end
                prev_v = ov1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit   ok;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        v1 = 1'b0; a1 = '0; b1 = '0; c1i = 1'b0; s1 = 1'b0; or1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_sum", out_sum, 32'd0);
        chk("rst_out_c", {31'd0, out_c}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed vectors, out_ready held high
        issue(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0);
        issue(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1);
        issue(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0);
        issue(32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1);
        issue(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0);
        issue(32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1);

        // Backpressure: second operand waits while the first result is held
        @(posedge clk); #1 out_ready = 1'b0;
        fork
            begin
                issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0);
                issue(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1);
            end
            begin
                ok = 1'b0;
                for (int i = 0; i < 100 && !ok; i++) begin
                    @(negedge clk);
                    if (out_valid) ok = 1'b1;
                end
                if (!ok) chk("bp_wait_valid", 32'd0, 32'd1);
                repeat (10) @(negedge clk);
                @(posedge clk); #1 out_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
                chk("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
            end
        join

        // Reset in the middle of RUN discards the pending result
        issue(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        q4.delete();
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0);

        // NBYTES=1 instance
        @(posedge clk); #1;
        a1 = 8'h80; b1 = 8'h80; c1i = 1'b0; s1 = 1'b0; v1 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (r1) ok = 1'b1;
        end
        if (!ok) begin
            chk("issue1_timeout", 32'd0, 32'd1);
        end else begin
            e.sum = 32'h00; e.c = 1'b1; e.xfer = cyc + 1;
            q1.push_back(e);
            @(posedge clk); #1;
        end
        v1 = 1'b0;

        // Drain
        for (int i = 0; i < 200 && (q4.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        chk("drain4", 32'(q4.size()), 32'd0);
        chk("drain1", 32'(q1.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
